// File: rtl/riscv_defines.sv
// Shared decode types, dispatch class indices and exec-unit to class mapping.
package riscv_defines;

  typedef enum logic [3:0] {
    ALU_UNIT    = 4'd0,
    BRANCH_UNIT = 4'd1,
    LOAD_UNIT   = 4'd2,
    STORE_UNIT  = 4'd3,
    FP_ALU_UNIT = 4'd4,
    FP_MUL_UNIT = 4'd5,
    FP_DIV_UNIT = 4'd6
  } exec_unit_t;

  typedef struct packed {
    logic       valid;
    exec_unit_t exec_unit;
    logic [4:0] rd;
    logic [31:0] pc;
  } decoded_inst_t;

  localparam int NUM_DISP_CLASSES = 6;
  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_BRANCH = 3'd1;
  localparam logic [2:0] CLS_LSU    = 3'd2;
  localparam logic [2:0] CLS_FP_ALU = 3'd3;
  localparam logic [2:0] CLS_FP_MUL = 3'd4;
  localparam logic [2:0] CLS_FP_DIV = 3'd5;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } disp_class_t;

  function automatic disp_class_t map_exec_unit(exec_unit_t u);
    disp_class_t c;
    c = '{hit: 1'b1, idx: CLS_ALU};
    unique case (u)
      ALU_UNIT:    c.idx = CLS_ALU;
      BRANCH_UNIT: c.idx = CLS_BRANCH;
      LOAD_UNIT,
      STORE_UNIT:  c.idx = CLS_LSU;
      FP_ALU_UNIT: c.idx = CLS_FP_ALU;
      FP_MUL_UNIT: c.idx = CLS_FP_MUL;
      FP_DIV_UNIT: c.idx = CLS_FP_DIV;
      default:     c.hit = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dispatch_credit_ctr.sv
// Saturating credit counter for one execution-unit class.
module dispatch_credit_ctr #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic take,
  input  logic ret,
  output logic nonzero
);

  localparam int KW = $clog2(CREDITS + 1);

  logic [KW-1:0] credit;

  // take and ret together cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= KW'(CREDITS);
    end else begin
      unique case ({take, ret})
        2'b10: if (credit != '0) credit <= credit - 1'b1;
        2'b01: if (credit != KW'(CREDITS)) credit <= credit + 1'b1;
        default: ;
      endcase
    end
  end

  assign nonzero = (credit != '0);

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order credit-based dispatch buffer; DISPATCH_PERF_CNT_EN adds stall_cnt.
module dispatch_scheduler
  import riscv_defines::*;
#(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  decoded_inst_t               in_inst,
  input  logic                        flush,
  input  logic [NUM_DISP_CLASSES-1:0] credit_ret,
  output logic [NUM_DISP_CLASSES-1:0] disp_valid,
  output decoded_inst_t               disp_inst,
  output logic                        drop_illegal
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  decoded_inst_t mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [NUM_DISP_CLASSES-1:0] credit_nz;

  disp_class_t head_cls;
  logic        has_head;
  logic        disp_fire;
  logic        enq;
  logic        deq;

  assign in_ready  = !rst && (count != CW'(DEPTH));
  assign enq       = in_valid && in_ready && in_inst.valid && !flush;
  assign disp_inst = mem[rd_ptr];
  assign has_head  = !rst && !flush && (count != '0);

  always_comb begin
    head_cls     = map_exec_unit(disp_inst.exec_unit);
    disp_fire    = has_head && head_cls.hit && credit_nz[head_cls.idx];
    drop_illegal = has_head && !head_cls.hit;
    deq          = disp_fire || drop_illegal;
    disp_valid   = '0;
    if (disp_fire)
      disp_valid = NUM_DISP_CLASSES'(1) << head_cls.idx;
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_inst;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DISP_CLASSES; i++) begin : g_cred
    dispatch_credit_ctr #(
      .CREDITS (CREDITS)
    ) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .take    (disp_valid[i]),
      .ret     (credit_ret[i]),
      .nonzero (credit_nz[i])
    );
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic stall;
  assign stall = has_head && head_cls.hit && !credit_nz[head_cls.idx];

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed plus random bench for dispatch_scheduler against a queue model.
module tb_dispatch_scheduler;
  import riscv_defines::*;

  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  decoded_inst_t in_inst;
  logic          flush;
  logic [5:0]    credit_ret;
  logic [5:0]    disp_valid;
  decoded_inst_t disp_inst;
  logic          drop_illegal;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  dispatch_scheduler #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .flush        (flush),
    .credit_ret   (credit_ret),
    .disp_valid   (disp_valid),
    .disp_inst    (disp_inst),
    .drop_illegal (drop_illegal)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  decoded_inst_t q[$];
  int            cred[6];
  longint        mstall;
  int            cls_of[16];

  decoded_inst_t nop;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic decoded_inst_t mk(input int unit);
    decoded_inst_t d;
    d.valid     = 1'b1;
    d.exec_unit = exec_unit_t'(4'(unit));
    d.rd        = 5'($urandom);
    d.pc        = $urandom;
    return d;
  endfunction

  task automatic step(input logic r, input logic iv, input decoded_inst_t ii,
                      input logic fl, input logic [5:0] cr);
    logic       e_rdy;
    logic [5:0] e_dv;
    logic       e_drop;
    logic       e_stall;
    int         c;
    rst = r; in_valid = iv; in_inst = ii; flush = fl; credit_ret = cr;
    #1;
    e_rdy   = !r && (q.size() != DEPTH);
    e_dv    = '0;
    e_drop  = 1'b0;
    e_stall = 1'b0;
    if (!r && !fl && q.size() > 0) begin
      c = cls_of[int'(q[0].exec_unit)];
      if (c < 0) e_drop = 1'b1;
      else if (cred[c] > 0) e_dv = 6'(1 << c);
      else e_stall = 1'b1;
    end
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    chk("disp_valid", 64'(disp_valid), 64'(e_dv));
    chk("drop_illegal", 64'(drop_illegal), 64'(e_drop));
    if (e_dv != 0) chk("disp_inst", 64'(disp_inst), 64'(q[0]));
`ifdef DISPATCH_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
`endif
    @(posedge clk);
    if (r) begin
      q.delete();
      foreach (cred[i]) cred[i] = CREDITS;
      mstall = 0;
    end else begin
      if (e_stall && mstall < 64'hFFFF_FFFF) mstall++;
      if (e_dv != 0 || e_drop) void'(q.pop_front());
      for (int i = 0; i < 6; i++) begin
        if (e_dv[i] && !cr[i]) cred[i]--;
        else if (cr[i] && !e_dv[i] && cred[i] < CREDITS) cred[i]++;
      end
      if (fl) q.delete();
      else if (iv && e_rdy && ii.valid) q.push_back(ii);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, nop, 1'b0, 6'b0);
  endtask

  task automatic enq(input int unit);
    step(1'b0, 1'b1, mk(unit), 1'b0, 6'b0);
  endtask

  task automatic ret(input logic [5:0] cr);
    step(1'b0, 1'b0, nop, 1'b0, cr);
  endtask

  initial begin
    decoded_inst_t d;
    foreach (cls_of[i]) cls_of[i] = -1;
    cls_of[0] = 0; cls_of[1] = 1; cls_of[2] = 2; cls_of[3] = 2;
    cls_of[4] = 3; cls_of[5] = 4; cls_of[6] = 5;
    nop = '0;
    foreach (cred[i]) cred[i] = CREDITS;
    mstall = 0;
    rst = 1'b1; in_valid = 1'b0; in_inst = nop; flush = 1'b0; credit_ret = '0;
    @(negedge clk);

    // reset overrides flush and in_valid
    step(1'b1, 1'b1, mk(0), 1'b1, 6'b111111);
    step(1'b1, 1'b1, mk(0), 1'b0, 6'b0);

    // three back-to-back ALU ops, credit ends at 1
    enq(0); enq(0); enq(0);
    idle(3);
    ret(6'b000001); ret(6'b000001); ret(6'b000001);

    // five FP_DIV: four go, fifth stalls until one credit returns
    for (int i = 0; i < 5; i++) enq(6);
    idle(4);
    ret(6'b100000);
    idle(2);

    // fill buffer behind blocked head, then one more offered
    for (int i = 0; i < 5; i++) enq(6);
    enq(0);
    ret(6'b100000);
    idle(1);

    // flush with three buffered and a new offer; credit return still lands
    step(1'b0, 1'b1, mk(0), 1'b1, 6'b100000);
    idle(2);
    enq(6); enq(6);
    idle(3);

    // reset mid-stall
    step(1'b1, 1'b0, nop, 1'b0, 6'b0);
    idle(2);

    // LSU credit to zero, return and head together, then cancel at 2
    enq(2); enq(3); enq(2); enq(3);
    enq(2);
    idle(1);
    ret(6'b000100);
    idle(1);
    ret(6'b000100); ret(6'b000100);
    enq(3);
    ret(6'b000100);
    enq(2); enq(2); enq(2);
    idle(2);
    ret(6'b000100); ret(6'b000100); ret(6'b000100); ret(6'b000100);
    idle(2);

    // illegal exec_unit dropped, next op dispatches right after
    enq(9); enq(0);
    idle(3);

    // handshake with inst.valid=0 is consumed without enqueue
    d = mk(1); d.valid = 1'b0;
    step(1'b0, 1'b1, d, 1'b0, 6'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      d = mk(int'($urandom_range(0, 8)));
      if ($urandom_range(0, 9) == 0) d.valid = 1'b0;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) != 0), d,
           ($urandom_range(0, 24) == 0),
           6'($urandom) & 6'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_scheduler.md
DISPATCH_SCHEDULER -- requirements
Module: dispatch_scheduler

Interface
REQ-001 Parameter: DEPTH, 4, instruction buffer entries; power of two, at least 2.
REQ-002 Parameter: CREDITS, 4, initial and maximum credits per execution-unit class.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  in  1  decoder offers an instruction.
REQ-006 Port: in_ready  out  1  buffer can accept an instruction.
REQ-007 Port: in_inst  in  decoded_inst_t  decoded instruction from the decoder.
REQ-008 Port: flush  in  1  discard all buffered instructions.
REQ-009 Port: credit_ret  in  6  one bit per class; a set bit returns one credit to that class.
REQ-010 Port: disp_valid  out  6  one-hot dispatch strobe, bit order [ALU, BRANCH, LSU, FP_ALU, FP_MUL, FP_DIV].
REQ-011 Port: disp_inst  out  decoded_inst_t  buffer head, valid when any disp_valid bit is set.
REQ-012 Port: drop_illegal  out  1  single-cycle pulse when the head is discarded for an unknown exec_unit.
REQ-013 Port: stall_cnt  out  32  count of cycles the head was blocked on credit; present only with DISPATCH_PERF_CNT_EN.

Function
REQ-014 The buffer SHALL be a circular FIFO of DEPTH entries, with read/write pointers wrapping modulo DEPTH and an occupancy count of width clog2(DEPTH)+1.
REQ-015 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on a dequeue in the same cycle.
REQ-016 An enqueue SHALL occur when in_valid && in_ready && in_inst.valid && !flush; a handshake with in_inst.valid=0 SHALL be consumed without enqueueing.
REQ-017 Each class SHALL keep a credit counter in 0..CREDITS; exec_unit maps ALU_UNIT→ALU, BRANCH_UNIT→BRANCH, LOAD_UNIT and STORE_UNIT→LSU, FP_ALU_UNIT→FP_ALU, FP_MUL_UNIT→FP_MUL, FP_DIV_UNIT→FP_DIV.
REQ-018 The head SHALL dispatch when count>0, !flush and the mapped credit is >0; disp_valid SHALL then be one-hot on that class, the head SHALL dequeue, and the credit SHALL decrement at the next edge.
REQ-019 Dispatch is in order with at most one instruction per cycle; a blocked head SHALL block all younger entries.
REQ-020 Latency: an instruction enqueued at edge N SHALL be presented at the earliest in the cycle following edge N; there is no bypass from in_inst to disp_inst.
REQ-021 A head whose exec_unit maps to no class SHALL dequeue without dispatch, pulse drop_illegal, and leave all credits unchanged.
REQ-022 A credit return and a dispatch on the same class in the same cycle SHALL leave that counter unchanged.
REQ-023 A credit return to a counter already at CREDITS SHALL be ignored (saturate); a counter SHALL never go below 0.
REQ-024 flush SHALL force disp_valid=0 and drop_illegal=0 in its cycle, block enqueue, and leave count=0 with pointers at 0 after the edge.
REQ-025 flush SHALL NOT alter credit counters; credit returns in the flush cycle SHALL still be applied.
REQ-026 An enqueue and a dequeue in the same cycle SHALL leave count unchanged.

Reset
REQ-027 On rst high at an edge: FIFO empty, pointers 0, every credit = CREDITS, stall_cnt = 0.
REQ-028 While rst is high, disp_valid=0, drop_illegal=0 and in_ready=0; rst SHALL override flush and all other inputs, including mid-stall.

Configuration
REQ-029 With DISPATCH_PERF_CNT_EN defined, stall_cnt SHALL increment each cycle with count>0, !flush and the head's mapped credit = 0, saturating at 32'hFFFF_FFFF.
REQ-030 Without DISPATCH_PERF_CNT_EN, the stall_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Class indices, NUM_DISP_CLASSES=6 and the exec_unit-to-class mapping function SHALL live in riscv_defines; decoded_inst_t and exec_unit_t are reused from that package.
REQ-032 The credit counter SHALL be one sub-module, dispatch_credit_ctr, instantiated once per class.

Verification
REQ-033 After reset, enqueue 3 ALU_UNIT instructions back-to-back → disp_valid=6'b000001 on 3 consecutive cycles starting one cycle after the first enqueue; ALU credit ends at 1.
REQ-034 With CREDITS=4, enqueue 5 FP_DIV_UNIT instructions and no credit_ret → 4 dispatch; the 5th holds; stall_cnt increments each cycle; one credit_ret[5] pulse → the 5th dispatches on the next cycle.
REQ-035 Hold the head blocked and enqueue until count=DEPTH=4 → in_ready=0; a further in_valid is not accepted; the buffer contents are unchanged.
REQ-036 With the LSU credit at 0, assert credit_ret[2] and the LSU head in the same cycle → no dispatch that cycle, dispatch on the next cycle; then credit_ret and dispatch together at credit 2 → credit stays 2.
REQ-037 Assert flush with 3 entries buffered and in_valid=1 → disp_valid=0 that cycle, count=0 afterwards, credits unchanged, the new instruction is not enqueued.
REQ-038 Enqueue an instruction with an undefined exec_unit → drop_illegal pulses for one cycle, no disp_valid bit is set, and the following instruction dispatches on the next cycle.
